frame_buffer_ctrl: RTL
======================

FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

Interface
REQ-001 Parameter H_PIX, default 160: captured pixels per line.
REQ-002 Parameter V_PIX, default 120: captured lines per frame; H_PIX*V_PIX SHALL be even and no greater than 32768.
REQ-003 Parameter FIFO_DEPTH, default 4: write-word FIFO depth, power of two.
REQ-004 Clock and reset: one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  system clock, 25 MHz.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 enable  in  1  capture enable; typically the SCCB config done flag.
REQ-008 frame_start  in  1  one-cycle pulse at the start of a camera frame, already in the clk domain.
REQ-009 pix_valid  in  1  one-cycle strobe: pix_data holds a valid RGB565 pixel.
REQ-010 pix_data  in  16  RGB565 pixel.
REQ-011 rd_en  in  1  VGA read request.
REQ-012 rd_addr  in  14  VGA read word address.
REQ-013 rd_data  out  16  read word; holds two grey pixels, the even pixel in [15:8].
REQ-014 rd_valid  out  1  rd_data is valid.
REQ-015 sram_addr  out  14  SP256K address.
REQ-016 sram_di  out  16  SP256K write data.
REQ-017 sram_we  out  1  SP256K write enable.
REQ-018 sram_do  in  16  SP256K read data.
REQ-019 frame_ready  out  1  one-cycle pulse: the last word of the frame is committed to SRAM.
REQ-020 overflow  out  1  sticky flag: a word was dropped in the current frame.

Function
REQ-021 Greyscale conversion:
- Expand each channel to 8 bits: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- Y = (2*R8 + 5*G8 + B8) >> 3, computed with an 11-bit sum and truncated to 8 bits.
REQ-022 Pixel packing: the first pixel after frame_start, and every alternate pixel after it, SHALL be latched into [15:8]; the next pixel completes the word in [7:0] and pushes it into the FIFO.
REQ-023 Write address: starts at 0 after each frame_start and increments by 1 per word pushed.
REQ-024 Frame length: WORDS = H_PIX*V_PIX/2.
REQ-025 State machine states: IDLE, CAPTURE, HOLD.
- IDLE -> CAPTURE on frame_start while enable=1.
- CAPTURE -> HOLD after word WORDS-1 is pushed.
- HOLD -> CAPTURE on frame_start.
- Any state -> IDLE when enable=0.
REQ-026 pix_valid SHALL be ignored in IDLE and HOLD.
REQ-027 Port arbitration, per cycle:
- If rd_en=1, the SRAM port serves the read: sram_we=0, sram_addr=rd_addr.
- Otherwise, if the FIFO is non-empty, the head word is written: sram_we=1, and the FIFO is popped.
REQ-028 Read latency: rd_valid SHALL assert exactly 1 cycle after rd_en, with rd_data=sram_do.
REQ-029 frame_ready SHALL pulse in the cycle after SRAM accepts the write of word WORDS-1.
REQ-030 FIFO full: if a word completes while the FIFO is full, that word is dropped, overflow is set, and the write address still increments so the frame stays aligned.
REQ-031 frame_start coincident with pix_valid: frame_start wins; the FIFO is flushed, the address is zeroed, and that pixel becomes the even pixel of word 0.
REQ-032 frame_start arriving mid-frame in CAPTURE: restart at address 0, discard the pending half-word and the FIFO contents, clear overflow, and do not pulse frame_ready.
REQ-033 FIFO push and pop in the same cycle SHALL leave the occupancy unchanged; a push into a full FIFO is never accepted, even when a pop occurs in that cycle.

Reset
REQ-034 While rst_n=0 at a clk edge, the block SHALL enter IDLE with the FIFO empty, address 0 and the half-flag cleared.
REQ-035 Output reset values: sram_we=0, sram_addr=0, sram_di=0, rd_valid=0, rd_data=0, frame_ready=0, overflow=0.
REQ-036 Reset mid-frame SHALL abandon the frame without emitting any SRAM write.

Structure
REQ-037 A shared package SHALL hold the state enum (IDLE/CAPTURE/HOLD), the luma coefficients (2,5,1, shift 3) and the SRAM address width (14).
REQ-038 The FIFO SHALL be a sub-module named fb_word_fifo (synchronous, parameterised depth and width, with full/empty outputs).

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- Greyscale: enable=1, frame_start, pixels 16'hFFFF then 16'h0000 -> one write, sram_addr=0, sram_di=16'hFF00.
- Pure colour: pixels 16'hF800, 16'h07E0 -> sram_di=16'h3F9F.
- Full frame, no reads: H_PIX=4, V_PIX=2 -> words 0..3 written in order; frame_ready pulses once, 1 cycle after the word-3 write; pixels after that are ignored until the next frame_start.
- Read priority: rd_en held high for 10 cycles during capture with FIFO_DEPTH=4 and 12 pixels -> the fifth completed word is dropped, overflow=1, and the following word lands at address 5; rd_valid follows each rd_en by 1 cycle.
- Restart: frame_start coincident with pix_valid, after 3 words written -> the next write is at address 0, overflow clears, and no frame_ready pulse occurs.
- Reset: rst_n=0 for 1 cycle mid-frame -> all outputs at reset values the next cycle, state IDLE, and no sram_we until a new frame_start.

Source files
------------

// File: rtl/frame_buffer_ctrl_pkg.sv
// Shared types and constants for the camera-to-SRAM frame buffer controller.
// Holds the capture state enum, luma weights, SRAM geometry and the FIFO word layout.
package frame_buffer_ctrl_pkg;

    localparam int SRAM_AW    = 14;
    localparam int WORD_W     = 16;

    localparam int LUMA_R     = 2;
    localparam int LUMA_G     = 5;
    localparam int LUMA_B     = 1;
    localparam int LUMA_SHIFT = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } fb_state_e;

    // A queued word carries its own address so drops never shift later words.
    typedef struct packed {
        logic                 last;
        logic [SRAM_AW-1:0]   addr;
        logic [WORD_W-1:0]    data;
    } fb_word_t;

    function automatic logic [7:0] rgb565_to_grey(input logic [15:0] pix);
        logic [7:0]  r8;
        logic [7:0]  g8;
        logic [7:0]  b8;
        logic [10:0] sum;
        r8  = {pix[15:11], pix[15:13]};
        g8  = {pix[10:5],  pix[10:9]};
        b8  = {pix[4:0],   pix[4:2]};
        sum = 11'(LUMA_R * r8) + 11'(LUMA_G * g8) + 11'(LUMA_B * b8);
        return 8'(sum >> LUMA_SHIFT);
    endfunction

endpackage

// File: rtl/frame_buffer_ctrl_if.sv
// Single-port SRAM bus between the frame buffer controller and an SP256K macro.
interface frame_buffer_ctrl_if;
    import frame_buffer_ctrl_pkg::*;

    // Port protocol: sram_addr/sram_di/sram_we are valid in the cycle they are
    // driven; a write commits at the closing clock edge when sram_we=1. With
    // sram_we=0 the macro reads sram_addr and returns sram_do one cycle later.
    logic [SRAM_AW-1:0] sram_addr;
    logic [WORD_W-1:0]  sram_di;
    logic               sram_we;
    logic [WORD_W-1:0]  sram_do;

    modport master (
        output sram_addr,
        output sram_di,
        output sram_we,
        input  sram_do
    );

    modport slave (
        input  sram_addr,
        input  sram_di,
        input  sram_we,
        output sram_do
    );

endinterface

// File: rtl/fb_word_fifo.sv
// Synchronous show-ahead FIFO for packed grey words awaiting an SRAM write slot.
// DEPTH must be a power of two, at least 2; a push into a full FIFO is refused.
module fb_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Captures RGB565 camera pixels as packed 8-bit grey pairs into a single-port
// SRAM, sharing the port with VGA reads which always take priority.
module frame_buffer_ctrl
    import frame_buffer_ctrl_pkg::*;
#(
    parameter int H_PIX      = 160,
    parameter int V_PIX      = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                frame_start,
    input  logic                pix_valid,
    input  logic [15:0]         pix_data,
    input  logic                rd_en,
    input  logic [SRAM_AW-1:0]  rd_addr,
    output logic [15:0]         rd_data,
    output logic                rd_valid,
    frame_buffer_ctrl_if.master sram,
    output logic                frame_ready,
    output logic                overflow,
    output fb_state_e           state_dbg
);

    localparam int                 WORDS     = H_PIX * V_PIX / 2;
    localparam logic [SRAM_AW-1:0] LAST_ADDR = SRAM_AW'(WORDS - 1);
    localparam int                 FW        = $bits(fb_word_t);

    fb_state_e          state_q;
    logic               half_q;
    logic [7:0]         even_q;
    logic [SRAM_AW-1:0] waddr_q;
    logic               overflow_q;
    logic               rd_valid_q;
    logic               frame_ready_q;

    logic [7:0]         grey;
    logic               start;
    logic               push_req;
    logic               wr_fire;
    logic               fifo_full;
    logic               fifo_empty;
    fb_word_t           push_word;
    fb_word_t           head_word;
    logic [FW-1:0]      head_bits;

    assign grey  = rgb565_to_grey(pix_data);
    assign start = enable && frame_start;

    assign push_req = rst_n && enable && !frame_start && (state_q == CAPTURE) &&
                      pix_valid && half_q;

    // Writes are held off during reset and on a restart so stale words never land.
    assign wr_fire = rst_n && !rd_en && !fifo_empty && !start;

    assign push_word = '{last: (waddr_q == LAST_ADDR), addr: waddr_q, data: {even_q, grey}};
    assign head_word = fb_word_t'(head_bits);

    fb_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (start),
        .push_i  (push_req),
        .din_i   (push_word),
        .pop_i   (wr_fire),
        .dout_o  (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        sram.sram_we   = wr_fire;
        sram.sram_addr = '0;
        sram.sram_di   = '0;
        if (rd_en) begin
            sram.sram_addr = rd_addr;
        end else if (wr_fire) begin
            sram.sram_addr = head_word.addr;
            sram.sram_di   = head_word.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            half_q     <= 1'b0;
            even_q     <= '0;
            waddr_q    <= '0;
            overflow_q <= 1'b0;
        end else if (!enable) begin
            state_q <= IDLE;
            half_q  <= 1'b0;
        end else if (frame_start) begin
            // A coincident pixel becomes the even half of word 0.
            state_q    <= CAPTURE;
            waddr_q    <= '0;
            overflow_q <= 1'b0;
            half_q     <= pix_valid;
            even_q     <= grey;
        end else if (state_q == CAPTURE && pix_valid) begin
            if (!half_q) begin
                even_q <= grey;
                half_q <= 1'b1;
            end else begin
                half_q  <= 1'b0;
                waddr_q <= waddr_q + SRAM_AW'(1);
                if (fifo_full) overflow_q <= 1'b1;
                if (waddr_q == LAST_ADDR) state_q <= HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q    <= 1'b0;
            frame_ready_q <= 1'b0;
        end else begin
            rd_valid_q    <= rd_en;
            frame_ready_q <= wr_fire && head_word.last;
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_valid_q ? sram.sram_do : '0;
    assign frame_ready = frame_ready_q;
    assign overflow    = overflow_q;
    assign state_dbg   = state_q;

endmodule
